// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the RNBIP memory-stage controller: op codes, FSM states, SP reset value.
package mem_stage_ctrl_pkg;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpLoad  = 3'd1;
  localparam logic [2:0] OpStore = 3'd2;
  localparam logic [2:0] OpPush  = 3'd3;
  localparam logic [2:0] OpPop   = 3'd4;
  localparam logic [2:0] OpCall  = 3'd5;
  localparam logic [2:0] OpRet   = 3'd6;

  localparam logic [7:0] SpResetDefault = 8'hFF;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StPopRd = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bundle between EX/MEM, the memory-stage controller, the data memory and the WB stage.
interface mem_stage_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_r0;
  logic [DATA_W-1:0] in_rn;
  logic [ADDR_W-1:0] in_npc;
  logic [ADDR_W-1:0] SP_out;
  logic [ADDR_W-1:0] R0_out;
  logic [DATA_W-1:0] RN_out;
  logic [ADDR_W-1:0] NPC_out;
  logic              S2;
  logic              S5;
  logic              RD;
  logic              WR;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_is_pc;
  logic              sp_ovf;
  logic              sp_unf;

  modport master (
    input  in_valid, in_op, in_r0, in_rn, in_npc, mem_rdata,
    output in_ready, SP_out, R0_out, RN_out, NPC_out, S2, S5, RD, WR,
    output wb_valid, wb_data, wb_is_pc, sp_ovf, sp_unf
  );

  modport slave (
    output in_valid, in_op, in_r0, in_rn, in_npc, mem_rdata,
    input  in_ready, SP_out, R0_out, RN_out, NPC_out, S2, S5, RD, WR,
    input  wb_valid, wb_data, wb_is_pc, sp_ovf, sp_unf
  );
endinterface

// File: rtl/mem_sp_unit.sv
// Stack pointer with push/pop update and, under MEM_STACK_GUARD_EN, overflow/underflow guard
// with sticky flags. Without the macro SP wraps freely and the flags are tied low.
module mem_sp_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic              push_ok_o,
  output logic              pop_ok_o,
  output logic              ovf_o,
  output logic              unf_o
);
  logic [ADDR_W-1:0] sp_q, sp_d;

`ifdef MEM_STACK_GUARD_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  assign push_ok_o = (sp_q != '0);
  assign pop_ok_o  = (sp_q != SP_RESET);

  always_comb begin
    ovf_d = ovf_q | (push_i & ~push_ok_o);
    unf_d = unf_q | (pop_i & ~pop_ok_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`else
  assign push_ok_o = 1'b1;
  assign pop_ok_o  = 1'b1;
  assign ovf_o     = 1'b0;
  assign unf_o     = 1'b0;
`endif

  // Stack grows downward: push decrements, pop increments.
  always_comb begin
    sp_d = sp_q;
    if (push_i && push_ok_o) begin
      sp_d = sp_q - ADDR_W'(1);
    end else if (pop_i && pop_ok_o) begin
      sp_d = sp_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= SP_RESET;
    else        sp_q <= sp_d;
  end

  assign sp_o = sp_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// RNBIP memory-stage initiator: decodes memory ops, drives data-memory controls, owns SP and
// registers the write-back result. Stack guard is compiled in with MEM_STACK_GUARD_EN.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SP_RESET = SpResetDefault
) (
  input logic              clk,
  input logic              rst_n,
  mem_stage_ctrl_if.master bus
);
  state_e            state_q, state_d;
  logic              is_ret_q, is_ret_d;
  logic              pop_unf_q, pop_unf_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_is_pc_q, wb_is_pc_d;

  logic              rd, wr, s2, s5, ready, push, pop, push_ok, pop_ok;
  logic [ADDR_W-1:0] sp;

  mem_sp_unit #(
    .ADDR_W  (ADDR_W),
    .SP_RESET(SP_RESET)
  ) u_sp (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .pop_i    (pop),
    .sp_o     (sp),
    .push_ok_o(push_ok),
    .pop_ok_o (pop_ok),
    .ovf_o    (bus.sp_ovf),
    .unf_o    (bus.sp_unf)
  );

  always_comb begin
    state_d    = state_q;
    is_ret_d   = is_ret_q;
    pop_unf_d  = pop_unf_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_is_pc_d = wb_is_pc_q;
    rd         = 1'b0;
    wr         = 1'b0;
    s2         = 1'b0;
    s5         = 1'b1;
    ready      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          case (bus.in_op)
            OpLoad: begin
              rd         = 1'b1;
              wb_valid_d = 1'b1;
              wb_data_d  = bus.mem_rdata;
              wb_is_pc_d = 1'b0;
            end
            OpStore: wr = 1'b1;
            OpPush, OpCall: begin
              push = 1'b1;
              wr   = push_ok;
              s2   = 1'b1;
              s5   = (bus.in_op == OpPush);
            end
            // SP is incremented now so the read in StPopRd addresses the top-of-stack byte.
            OpPop, OpRet: begin
              pop       = 1'b1;
              pop_unf_d = ~pop_ok;
              is_ret_d  = (bus.in_op == OpRet);
              state_d   = StPopRd;
            end
            default: ;
          endcase
        end
      end
      StPopRd: begin
        rd         = ~pop_unf_q;
        s2         = 1'b1;
        wb_valid_d = 1'b1;
        wb_data_d  = pop_unf_q ? '0 : bus.mem_rdata;
        wb_is_pc_d = is_ret_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_ret_q   <= 1'b0;
      pop_unf_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_is_pc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_ret_q   <= is_ret_d;
      pop_unf_q  <= pop_unf_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_is_pc_q <= wb_is_pc_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.RD       = rd;
  assign bus.WR       = wr;
  assign bus.S2       = s2;
  assign bus.S5       = s5;
  assign bus.SP_out   = sp;
  assign bus.R0_out   = bus.in_r0;
  assign bus.RN_out   = bus.in_rn;
  assign bus.NPC_out  = bus.in_npc;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_is_pc = wb_is_pc_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a 256x8 memory model; guard checks follow
// MEM_STACK_GUARD_EN.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] addr;
  assign addr          = bus.S2 ? bus.SP_out : bus.R0_out;
  assign bus.mem_rdata = mem[addr];
  always @(posedge clk) if (bus.WR) mem[addr] <= bus.S5 ? bus.RN_out : bus.NPC_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] r0, input logic [7:0] rn,
                       input logic [7:0] npc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_r0    = r0;
    bus.in_rn    = rn;
    bus.in_npc   = npc;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = OpNop;
    bus.in_r0    = '0;
    bus.in_rn    = '0;
    bus.in_npc   = '0;

    // Reset state
    #12;
    chk("rst_sp", bus.SP_out, 8'hFF);
    chk("rst_rd", bus.RD, 1'b0);
    chk("rst_wr", bus.WR, 1'b0);
    chk("rst_s5", bus.S5, 1'b1);
    chk("rst_wbv", bus.wb_valid, 1'b0);
    chk("rst_wbd", bus.wb_data, 8'h00);
    chk("rst_pc", bus.wb_is_pc, 1'b0);
    chk("rst_ovf", bus.sp_ovf, 1'b0);
    chk("rst_unf", bus.sp_unf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", bus.in_ready, 1'b1);

    // STORE then LOAD through R0
    issue(OpStore, 8'h10, 8'hA5, 8'h00);
    chk("st_wr", bus.WR, 1'b1);
    chk("st_s2", bus.S2, 1'b0);
    chk("st_s5", bus.S5, 1'b1);
    chk("st_rd", bus.RD, 1'b0);
    edge_step();
    chk("st_nowb", bus.wb_valid, 1'b0);
    chk("st_mem", mem[8'h10], 8'hA5);
    issue(OpLoad, 8'h10, 8'h00, 8'h00);
    chk("ld_rd", bus.RD, 1'b1);
    chk("ld_s2", bus.S2, 1'b0);
    chk("ld_wr", bus.WR, 1'b0);
    edge_step();
    chk("ld_wbv", bus.wb_valid, 1'b1);
    chk("ld_wbd", bus.wb_data, 8'hA5);
    chk("ld_pc", bus.wb_is_pc, 1'b0);
    edge_step();
    chk("ld_pulse", bus.wb_valid, 1'b0);

    // PUSH then POP, with a STORE held by EX/MEM during POP_RD
    issue(OpPush, 8'h00, 8'h3C, 8'h00);
    chk("pu_wr", bus.WR, 1'b1);
    chk("pu_s2", bus.S2, 1'b1);
    chk("pu_s5", bus.S5, 1'b1);
    edge_step();
    chk("pu_sp", bus.SP_out, 8'hFE);
    chk("pu_mem", mem[8'hFF], 8'h3C);
    issue(OpPop, 8'h00, 8'h00, 8'h00);
    chk("po_rd0", bus.RD, 1'b0);
    chk("po_wr0", bus.WR, 1'b0);
    edge_step();
    chk("po_sp", bus.SP_out, 8'hFF);
    chk("po_ready", bus.in_ready, 1'b0);
    chk("po_rd", bus.RD, 1'b1);
    chk("po_s2", bus.S2, 1'b1);
    chk("po_nowb", bus.wb_valid, 1'b0);
    issue(OpStore, 8'h20, 8'h77, 8'h00);
    chk("hold_ready", bus.in_ready, 1'b0);
    chk("hold_wr", bus.WR, 1'b0);
    @(posedge clk);
    #1;
    chk("po_wbv", bus.wb_valid, 1'b1);
    chk("po_wbd", bus.wb_data, 8'h3C);
    chk("po_pc", bus.wb_is_pc, 1'b0);
    chk("hold_acc", bus.in_ready & bus.WR, 1'b1);
    edge_step();
    chk("hold_mem", mem[8'h20], 8'h77);
    chk("hold_nowb", bus.wb_valid, 1'b0);

    // CALL then RET
    issue(OpCall, 8'h00, 8'h99, 8'h42);
    chk("ca_s5", bus.S5, 1'b0);
    chk("ca_wr", bus.WR, 1'b1);
    edge_step();
    chk("ca_sp", bus.SP_out, 8'hFE);
    chk("ca_mem", mem[8'hFF], 8'h42);
    issue(OpRet, 8'h00, 8'h00, 8'h00);
    edge_step();
    chk("re_rd", bus.RD, 1'b1);
    edge_step();
    chk("re_wbv", bus.wb_valid, 1'b1);
    chk("re_wbd", bus.wb_data, 8'h42);
    chk("re_pc", bus.wb_is_pc, 1'b1);
    chk("re_sp", bus.SP_out, 8'hFF);

`ifdef MEM_STACK_GUARD_EN
    // Underflow: POP at SP_RESET reads nothing and returns zero
    issue(OpPop, 8'h00, 8'h00, 8'h00);
    edge_step();
    chk("gu_sp", bus.SP_out, 8'hFF);
    chk("gu_unf", bus.sp_unf, 1'b1);
    chk("gu_rd", bus.RD, 1'b0);
    edge_step();
    chk("gu_wbv", bus.wb_valid, 1'b1);
    chk("gu_wbd", bus.wb_data, 8'h00);
    // Overflow: the 256th PUSH lands on SP==0 and is suppressed
    for (int i = 0; i < 256; i++) begin
      issue(OpPush, 8'h00, 8'(i), 8'h00);
      if (i == 255) chk("go_wr", bus.WR, 1'b0);
      edge_step();
    end
    chk("go_sp", bus.SP_out, 8'h00);
    chk("go_ovf", bus.sp_ovf, 1'b1);
    chk("go_unf", bus.sp_unf, 1'b1);
    chk("go_mem", mem[8'h01], 8'hFE);
`else
    // Free wrap: POP at FF goes to 00, PUSH at 00 goes back to FF
    issue(OpPop, 8'h00, 8'h00, 8'h00);
    edge_step();
    chk("wr_sp0", bus.SP_out, 8'h00);
    chk("wr_rd", bus.RD, 1'b1);
    edge_step();
    issue(OpPush, 8'h00, 8'h5A, 8'h00);
    chk("wr_pwr", bus.WR, 1'b1);
    edge_step();
    chk("wr_spff", bus.SP_out, 8'hFF);
    chk("wr_mem", mem[8'h00], 8'h5A);
    chk("wr_ovf", bus.sp_ovf, 1'b0);
    chk("wr_unf", bus.sp_unf, 1'b0);
`endif

    // Reset asserted during POP_RD aborts the op
    issue(OpPop, 8'h00, 8'h00, 8'h00);
    edge_step();
    chk("ab_ready", bus.in_ready, 1'b0);
    chk("ab_rd", bus.RD, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_sp", bus.SP_out, 8'hFF);
    chk("ab_rd0", bus.RD, 1'b0);
    @(posedge clk);
    #1;
    chk("ab_nowb", bus.wb_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ab_idle", bus.in_ready, 1'b1);
    chk("ab_ovf", bus.sp_ovf, 1'b0);
    @(posedge clk);
    #1;
    chk("ab_nowb2", bus.wb_valid, 1'b0);
    chk("ab_sp2", bus.SP_out, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
